// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes over 32 RUN cycles, followed by a sign fixup that writes HI/LO.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;       // quotient/product sign differs from magnitude
    logic           a_neg_q, a_neg_d;   // remainder takes the dividend's sign
    logic [W-1:0]   a_raw_q, a_raw_d;
    logic [W-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [W-1:0]   acc_hi_q, acc_hi_d;
    logic [W-1:0]   acc_lo_q, acc_lo_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic           accept;
    logic           is_signed;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     sum, rem_sh, diff;
    logic [2*W-1:0] prod;

    assign accept    = start && !flush;
    assign is_signed = !op[0];
    assign a_mag     = (is_signed && a[W-1]) ? -a : a;
    assign b_mag     = (is_signed && b[W-1]) ? -b : b;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        prod     = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd31;
                    is_div_d = op[1];
                    neg_d    = is_signed && (a[W-1] ^ b[W-1]);
                    a_neg_d  = is_signed && a[W-1];
                    a_raw_d  = a;
                    opnd_d   = op[1] ? b_mag : a_mag;
                    acc_hi_d = '0;
                    acc_lo_d = op[1] ? a_mag : b_mag;
                end
            end
            S_RUN: begin
                if (!is_div_q) begin
                    sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
                    {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[W-1:1]};
                end else begin
                    // Partial remainder stays below the divisor, so the 33-bit sign bit is the borrow.
                    rem_sh = {acc_hi_q, acc_lo_q[W-1]};
                    diff   = rem_sh - {1'b0, opnd_q};
                    if (!diff[W]) begin
                        acc_hi_d = diff[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
                    end else begin
                        acc_hi_d = rem_sh[W-1:0];
                        acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
                    end
                end
                if (cnt_q == 5'd0) state_d = S_FIX;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!is_div_q) begin
                    prod = {acc_hi_q, acc_lo_q};
                    if (neg_q) prod = -prod;
                    {hi_d, lo_d} = prod;
                end else if (opnd_q == '0) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = a_neg_q ? -acc_hi_q : acc_hi_q;
                    lo_d = neg_q   ? -acc_lo_q : acc_lo_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign stall = rst && ((state_q == S_RUN) || (state_q == S_FIX) || accept);
    assign done  = (state_q == S_DONE);
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a cycle-count/arithmetic model checked every cycle,
// plus directed operations with hand-computed HI/LO and latency expectations.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        stall, done;
    logic [31:0] hi, lo;

    int n_pass = 0;
    int n_total = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural result of one operation, straight from integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] ux, uy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
        case (o)
            2'b00: return 64'(sx * sy);
            2'b01: return ux * uy;
            2'b10: begin
                q = 64'(sx / sy);
                r = 64'(sx % sy);
                return {r[31:0], q[31:0]};
            end
            default: begin
                q = ux / uy;
                r = ux % uy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Model: an accepted op is busy for 33 more cycles, then HI/LO update and done shows.
    int          m_rem;
    logic        m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_rem <= 0;
            end else if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_rem  <= 33;
                m_pend <= ref_result(op, a, b);
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_stall", stall, rst && (m_rem > 0 || (start && !flush)));
        check("cmp_done", done, m_done);
        check("cmp_hi", hi, m_hi);
        check("cmp_lo", lo, m_lo);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op in the current cycle and follows it to done; returns in the done cycle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int pulse_at);
        int  n;
        int  stalls;
        bit  seen;
        start = 1'b1; op = o; a = x; b = y; flush = 1'b0;
        #1;
        stalls = stall ? 1 : 0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            start = (n == pulse_at);
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            #1;
            if (done) seen = 1'b1;
            else if (stall) stalls++;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(n), 64'd34);
        check({name, "_stall_cycles"}, 64'(stalls), 64'd34);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        flush = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int dones;
        rst = 1'b0; start = 1'b1; flush = 1'b0; op = 2'b01; a = 32'd3; b = 32'd4;
        repeat (3) step();
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        start = 1'b0;
        rst = 1'b1;
        idle(2);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        idle(2);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("mult_b2b", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        idle(1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        idle(1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        idle(1);
        run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 0);
        idle(1);
        run_op("div_zero", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
        idle(1);
        run_op("divu_50_7", 2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 0);
        idle(2);

        // Flush in cycle 10 of a new op.
        start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd7;
        step();
        start = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_stall_k1", stall, 1'b0);
        dones = 0;
        repeat (40) begin
            step();
            if (done) dones++;
        end
        check("flush_no_done", 64'(dones), 64'd0);
        check("flush_hi", hi, 32'd1);
        check("flush_lo", lo, 32'd7);

        // Flush in FIX must not write HI/LO.
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        step();
        start = 1'b0;
        repeat (32) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        check("flush_fix_hi", hi, 32'd1);
        check("flush_fix_lo", lo, 32'd7);

        // Start with flush in IDLE is refused.
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        #1;
        check("start_flush_stall", stall, 1'b0);
        step();
        start = 1'b0; flush = 1'b0;
        #1;
        check("start_flush_not_accepted", stall, 1'b0);
        idle(2);

        run_op("multu_pulse", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 5);
        idle(2);

        // Reset in cycle 10 of an op abandons it.
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd1000;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b0;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_done", done, 1'b0);
        check("midrst_stall", stall, 1'b0);
        step();
        step();
        rst = 1'b1;
        dones = 0;
        repeat (40) begin
            step();
            if (done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        check("midrst_hi_after", hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
